// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - function codes, FSM state type and opcode legality for the ALU op scheduler
package alu_op_pkg;

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_NOP   = 6'd0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL,
      OP_MULTU, OP_MFHI, OP_MFLO: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_hilo(input logic [5:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/alu_op_arbiter.sv
// rtl/alu_op_arbiter.sv - two-way grant; round-robin pointer built only with ALU_OP_SCHED_RR_EN
module alu_op_arbiter
  import alu_op_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic grant_take,
  output logic gnt0,
  output logic gnt1
);

`ifdef ALU_OP_SCHED_RR_EN
  logic ptr_q, ptr_d;

  // ptr_q names the requester preferred on a tie; it moves past each winner
  always_comb begin
    gnt0  = req0_valid && (!req1_valid || !ptr_q);
    gnt1  = req1_valid && !gnt0;
    ptr_d = ptr_q;
    if (grant_take) ptr_d = gnt0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset, grant_take};
  assign gnt0       = req0_valid;
  assign gnt1       = req1_valid && !req0_valid;
`endif

endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - shares one TotalALU between two requesters; ALU_OP_SCHED_RR_EN selects round-robin
module alu_op_scheduler
  import alu_op_pkg::*;
#(
  parameter int RES_LAT    = 1,
  parameter int MUL_CYCLES = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int CNT_MAX = (MUL_CYCLES > RES_LAT) ? MUL_CYCLES : RES_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d, data_q, data_d;
  logic              id_q, id_d, err_q, err_d;
  logic              own_q, own_d, own_vld_q, own_vld_d;

  logic              gnt0, gnt1, idle, take, sel_id, hilo_ok;
  logic [5:0]        sel_op;

  assign idle    = (state_q == IDLE);
  assign take    = idle && (gnt0 || gnt1);
  assign sel_id  = gnt1;
  assign sel_op  = gnt1 ? req1_op : req0_op;
  assign hilo_ok = own_vld_q && (own_q == sel_id);

  alu_op_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant_take (take),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = idle && gnt0;
  assign req1_ready = idle && gnt1;
  assign alu_signal = (state_q == EXEC) ? op_q : OP_NOP;
  assign alu_a      = (state_q == EXEC) ? a_q : 32'd0;
  assign alu_b      = (state_q == EXEC) ? b_q : 32'd0;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    data_d    = data_q;
    err_d     = err_q;
    own_d     = own_q;
    own_vld_d = own_vld_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          op_d = sel_op;
          a_d  = gnt1 ? req1_a : req0_a;
          b_d  = gnt1 ? req1_b : req0_b;
          id_d = sel_id;
          // HI/LO reads are only honoured for the requester whose MULTU produced them
          if (!op_legal(sel_op) || (op_reads_hilo(sel_op) && !hilo_ok)) begin
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = (sel_op == OP_MULTU) ? CNT_W'(MUL_CYCLES) : CNT_W'(RES_LAT);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          data_d  = (op_q == OP_MULTU) ? 32'd0 : alu_result;
          state_d = RESP;
          if (op_q == OP_MULTU) begin
            own_d     = id_q;
            own_vld_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      id_q      <= 1'b0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
      own_q     <= 1'b0;
      own_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      data_q    <= data_d;
      err_q     <= err_d;
      own_q     <= own_d;
      own_vld_q <= own_vld_d;
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - directed bench for alu_op_scheduler with a behavioural TotalALU
module tb_alu_op_scheduler;
  import alu_op_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_op, req1_op, alu_signal;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.RES_LAT(1), .MUL_CYCLES(33)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always_comb begin
    case (alu_signal)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SRL:  alu_result = alu_a >> alu_b[4:0];
      OP_MFHI: alu_result = hi_m;
      OP_MFLO: alu_result = lo_m;
      default: alu_result = 32'd0;
    endcase
  end

  always @(posedge clk)
    if (alu_signal == OP_MULTU) {hi_m, lo_m} <= {32'd0, alu_a} * {32'd0, alu_b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    @(negedge clk);
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int w = 0; w < 40 && !got; w++) begin
      #1;
      if (id ? req1_ready : req0_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_rsp(output int lat, output int execn);
    bit got = 0;
    lat = 0;
    execn = 0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (alu_signal != OP_NOP) execn++;
      if (rsp_valid) got = 1;
      else lat++;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
  endtask

  task automatic run_op(input string name, input logic id, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int exp_exec);
    int lat, execn;
    start_op(id, op, a, b);
    wait_rsp(lat, execn);
    chk({name, "_data"}, rsp_data, exp_data);
    chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_exec"}, 32'(execn), 32'(exp_exec));
    release_rsp();
  endtask

  typedef struct {
    string       name;
    logic        id;
    logic [5:0]  op;
    logic [31:0] a, b, data;
    logic        err;
    int          lat, execn;
  } vec_t;

  vec_t vt[8];
  int   g[3];
  int   ng;
  int   lat, execn;
  bit   stable;
  logic [31:0] exp_order;

  initial begin
    vt[0] = '{"add",    1'b0, OP_ADD,   32'd5,        32'd7,      32'd12,     1'b0, 1, 1};
    vt[1] = '{"and",    1'b1, OP_AND,   32'hF0F0,     32'hFF00,   32'hF000,   1'b0, 1, 1};
    vt[2] = '{"or",     1'b0, OP_OR,    32'hF0F0,     32'h0F0F,   32'hFFFF,   1'b0, 1, 1};
    vt[3] = '{"sub",    1'b1, OP_SUB,   32'd10,       32'd3,      32'd7,      1'b0, 1, 1};
    vt[4] = '{"slt",    1'b0, OP_SLT,   32'hFFFFFFFF, 32'd1,      32'd1,      1'b0, 1, 1};
    vt[5] = '{"srl",    1'b1, OP_SRL,   32'h80,       32'd3,      32'h10,     1'b0, 1, 1};
    vt[6] = '{"ill7",   1'b0, 6'd7,     32'd1,        32'd2,      32'd0,      1'b1, 0, 0};
    vt[7] = '{"mfhi_no", 1'b1, OP_MFHI, 32'd0,        32'd0,      32'd0,      1'b1, 0, 0};

    reset = 1; rsp_ready = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_signal", 32'(alu_signal), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_ctrl", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err}), 32'd0);
    reset = 0;

    // both requesters continuously valid
`ifdef ALU_OP_SCHED_RR_EN
    exp_order = 32'b010;
`else
    exp_order = 32'b000;
`endif
    rsp_ready = 1;
    @(negedge clk);
    req0_valid = 1; req0_op = OP_SUB; req0_a = 9; req0_b = 4;
    req1_valid = 1; req1_op = OP_SUB; req1_a = 8; req1_b = 1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      #1;
      if (req0_ready)      begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      if (ng < 3) @(negedge clk);
    end
    chk("arb_grants", 32'(ng), 32'd3);
    chk("arb_order", 32'({g[0][0], g[1][0], g[2][0]}), exp_order);
    @(posedge clk);
    #1;
    req0_valid = 0; req1_valid = 0;
    repeat (6) @(negedge clk);
    rsp_ready = 0;

    for (int i = 0; i < 8; i++)
      run_op(vt[i].name, vt[i].id, vt[i].op, vt[i].a, vt[i].b, vt[i].data, vt[i].err, vt[i].lat, vt[i].execn);

    run_op("multu1", 1'b1, OP_MULTU, 32'h10000, 32'h10000, 32'd0, 1'b0, 33, 33);
    run_op("mfhi1",  1'b1, OP_MFHI,  32'd0, 32'd0, 32'd1, 1'b0, 1, 1);
    run_op("mflo1",  1'b1, OP_MFLO,  32'd0, 32'd0, 32'd0, 1'b0, 1, 1);
    run_op("mflo0x", 1'b0, OP_MFLO,  32'd0, 32'd0, 32'd0, 1'b1, 0, 0);
    run_op("multu0", 1'b0, OP_MULTU, 32'd3, 32'd5, 32'd0, 1'b0, 33, 33);
    run_op("mflo0",  1'b0, OP_MFLO,  32'd0, 32'd0, 32'd15, 1'b0, 1, 1);
    run_op("mfhi1x", 1'b1, OP_MFHI,  32'd0, 32'd0, 32'd0, 1'b1, 0, 0);

    // response back-pressure with both requesters waiting
    start_op(1'b0, OP_ADD, 32'd1, 32'd2);
    wait_rsp(lat, execn);
    chk("hold_data", rsp_data, 32'd3);
    req0_valid = 1; req0_op = OP_ADD;
    req1_valid = 1; req1_op = OP_AND;
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid || rsp_data !== 32'd3 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || req0_ready || req1_ready)
        stable = 0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    req0_valid = 0; req1_valid = 0;
    release_rsp();

    // reset in the middle of a MULTU
    start_op(1'b1, OP_MULTU, 32'd2, 32'd3);
    repeat (10) @(negedge clk);
    chk("mid_exec_sig", 32'(alu_signal), 32'(OP_MULTU));
    reset = 1;
    @(posedge clk);
    #1;
    chk("abort_alu_signal", 32'(alu_signal), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_ctrl", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err}), 32'd0);
    chk("abort_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    reset = 0;
    run_op("mfhi_after_rst", 1'b1, OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
